// File: rtl/sysid_ctrl_pkg.sv
// Shared definitions for the system-ID check sequencer: FSM encoding,
// sysid slave word addresses and the default expected contents.
package sysid_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_ID = 3'd1,
    ST_WAIT_TS = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1367720487;

  // Increment an 8-bit event counter, sticking at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sysid_recheck_timer.sv
// 32-bit down-counter used to trigger periodic re-checks. Loaded with the
// period on entry to DONE; expire is asserted on the last counted cycle.
module sysid_recheck_timer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        enable,
  input  logic        clear,
  output logic        expire
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: load wins over clear, otherwise count down while enabled.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != 32'd0)) begin
      count_d = count_q - 32'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A loaded value of P expires on the P-th enabled cycle.
  assign expire = enable && (count_q == 32'd1);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Sequencer owning the sysid slave control port: reads the ID and build
// timestamp words, compares them against build-time values, retries a
// bounded number of times and reports the result.
module sysid_check_ctrl
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter logic [31:0] RECHECK_PERIOD     = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] captured_id,
  output logic [31:0] captured_timestamp,
  output logic [7:0]  mismatch_count
);

  localparam logic [2:0] LAT_LOAD    = 3'(READ_LATENCY);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  sysid_state_e state_q, state_d;
  logic [2:0]   wait_q, wait_d;
  logic [3:0]   retry_q, retry_d;
  logic [31:0]  cap_id_q, cap_id_d;
  logic [31:0]  cap_ts_q, cap_ts_d;
  logic         id_ok_q, id_ok_d;
  logic         ts_ok_q, ts_ok_d;
  logic [7:0]   mcount_q, mcount_d;
  logic         done_q, done_d;
  logic         recheck_expire;

  // Sequencer next-state: countdown per word, capture, compare, retry.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    retry_d  = retry_q;
    cap_id_d = cap_id_q;
    cap_ts_d = cap_ts_q;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    mcount_d = mcount_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_ID;
          wait_d  = LAT_LOAD;
          retry_d = '0;
        end
      end
      ST_WAIT_ID: begin
        if (wait_q == 3'd0) begin
          cap_id_d = sysid_readdata;
          wait_d   = LAT_LOAD;
          state_d  = ST_WAIT_TS;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_WAIT_TS: begin
        if (wait_q == 3'd0) begin
          cap_ts_d = sysid_readdata;
          state_d  = ST_COMPARE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_COMPARE: begin
        id_ok_d = (cap_id_q == EXPECTED_ID);
        ts_ok_d = (cap_ts_q == EXPECTED_TIMESTAMP);
        if (id_ok_d && ts_ok_d) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          mcount_d = sat_inc8(mcount_q);
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 4'd1;
            wait_d  = LAT_LOAD;
            state_d = ST_WAIT_ID;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // A coincident start and timer expiry still launch just one pass.
        if (start || recheck_expire) begin
          state_d = ST_WAIT_ID;
          wait_d  = LAT_LOAD;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset drops any sequence in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      retry_q  <= '0;
      cap_id_q <= '0;
      cap_ts_q <= '0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      mcount_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      retry_q  <= retry_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      mcount_q <= mcount_d;
      done_q   <= done_d;
    end
  end

  // Periodic re-check timer exists only when a period is configured.
  generate
    if (RECHECK_PERIOD != 32'd0) begin : g_recheck
      logic in_done;
      logic tmr_load;
      assign in_done  = (state_q == ST_DONE);
      assign tmr_load = (state_d == ST_DONE) && !in_done;
      sysid_recheck_timer u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (RECHECK_PERIOD),
        .enable     (in_done),
        .clear      (!in_done),
        .expire     (recheck_expire)
      );
    end else begin : g_no_recheck
      assign recheck_expire = 1'b0;
    end
  endgenerate

  // Address follows the state register, so it only moves on state entry.
  assign sysid_address      = (state_q == ST_WAIT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy               = (state_q == ST_WAIT_ID) || (state_q == ST_WAIT_TS) ||
                              (state_q == ST_COMPARE);
  assign done               = done_q;
  assign id_ok              = id_ok_q;
  assign ts_ok              = ts_ok_q;
  assign captured_id        = cap_id_q;
  assign captured_timestamp = cap_ts_q;
  assign mismatch_count     = mcount_q;

endmodule
